// File: rtl/dmem_pipe.sv
// Word-organised data memory: valid/ready request port, in-order response pipeline of
// configurable latency, zero-fill sweep after reset. Byte strobes enabled by DMEM_WSTRB_EN.
module dmem_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wen,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [DATA_W-1:0]     i_req_wdata,
  input  logic [DATA_W/8-1:0]   i_req_wstrb,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_wr,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_init_done
);

  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(BYTES);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   cnt, cnt_next;
  logic               init_we;
  logic               ready_q, init_done_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic [63:0]        addr64;
  logic               req_err;
  logic [IDX_W-1:0]   req_idx;
  logic               mem_we;

  logic [LATENCY-1:0] stg_valid, stg_wr, stg_err;
  logic [DATA_W-1:0]  stg_rdata [LATENCY];

  // FSM state and sweep counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_we    = 1'b0;
    unique case (state)
      S_INIT: begin
        init_we  = 1'b1;
        cnt_next = cnt + IDX_W'(1);
        if (cnt == IDX_W'(DEPTH - 1)) state_next = S_RUN;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // ready/init_done track the state the FSM is about to enter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      ready_q     <= (state_next == S_RUN);
      init_done_q <= (state_next == S_RUN);
    end
  end

  assign o_req_ready = ready_q;
  assign o_init_done = init_done_q;

  // Request decode: alignment and range checked on the full byte address
  assign accept  = i_req_valid & ready_q;
  assign addr64  = 64'(i_req_addr);
  assign req_err = ((addr64 % 64'(BYTES)) != 64'd0) || (addr64 >= MEM_BYTES);
  assign req_idx = IDX_W'(addr64 / 64'(BYTES));
  assign mem_we  = accept & i_req_wen & ~req_err;

  // Storage: sweep writes take priority; no requests are accepted while sweeping
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (init_we) begin
        mem[cnt] <= '0;
      end else if (mem_we) begin
`ifdef DMEM_WSTRB_EN
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (i_req_wstrb[b]) mem[req_idx][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
        end
`else
        mem[req_idx] <= i_req_wdata;
`endif
      end
    end
  end

`ifndef DMEM_WSTRB_EN
  logic unused_wstrb;
  assign unused_wstrb = ^i_req_wstrb;
`endif

  // Response pipeline; stage 0 captures the read at the acceptance edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stg_valid <= '0;
      stg_wr    <= '0;
      stg_err   <= '0;
      for (int k = 0; k < int'(LATENCY); k++) stg_rdata[k] <= '0;
    end else begin
      for (int k = int'(LATENCY) - 1; k > 0; k--) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_wr[k]    <= stg_wr[k-1];
        stg_err[k]   <= stg_err[k-1];
        stg_rdata[k] <= stg_rdata[k-1];
      end
      stg_valid[0] <= accept;
      stg_wr[0]    <= accept & i_req_wen;
      stg_err[0]   <= accept & req_err;
      stg_rdata[0] <= (accept && !i_req_wen && !req_err) ? mem[req_idx] : '0;
    end
  end

  assign o_rsp_valid = stg_valid[LATENCY-1];
  assign o_rsp_wr    = stg_wr[LATENCY-1];
  assign o_rsp_err   = stg_err[LATENCY-1];
  assign o_rsp_rdata = stg_rdata[LATENCY-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe: directed scenarios plus random traffic against a
// word-array reference model with per-response latency tracking.
module tb_dmem_pipe;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned LAT   = 2;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_wen = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0;
  logic [3:0]    i_req_wstrb = '0;
  logic          o_rsp_valid;
  logic          o_rsp_wr;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_init_done;

  dmem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wen(i_req_wen), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_rsp_valid(o_rsp_valid), .o_rsp_wr(o_rsp_wr),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  rsp_t        obs[$];
  rsp_t        exp_q[$];
  rsp_t        col_r;
  logic [31:0] mdl [DEPTH];
  int          cyc = 0;
  int          idle_bad = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response collector: records every pulse with the cycle it was seen in
  always @(negedge clk) begin
    if (o_rsp_valid === 1'b1) begin
      col_r.wr = o_rsp_wr; col_r.err = o_rsp_err; col_r.rdata = o_rsp_rdata; col_r.cyc = cyc;
      obs.push_back(col_r);
    end else if (o_rsp_rdata !== 32'h0) begin
      idle_bad++;
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
    exp_q.delete();
  endfunction

  // Reference: apply one accepted request to the word array and queue its response
  function automatic void model_req(input logic wen, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] strb);
    rsp_t r;
    int   idx;
    r.wr = wen;
    r.err = ((addr % 4) != 0) || (addr >= 32'(DEPTH * 4));
    r.rdata = 32'h0;
    r.cyc = cyc + int'(LAT);
    if (!r.err) begin
      idx = int'(addr / 4);
      if (wen) begin
`ifdef DMEM_WSTRB_EN
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = wdata[b*8 +: 8];
`else
        mdl[idx] = wdata;
        if (strb == 4'hF) mdl[idx] = wdata;
`endif
      end else begin
        r.rdata = mdl[idx];
      end
    end
    exp_q.push_back(r);
  endfunction

  task automatic cycle_req(input logic v, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    @(negedge clk);
    i_req_valid = v; i_req_wen = wen; i_req_addr = addr;
    i_req_wdata = wdata; i_req_wstrb = strb;
    if (v && o_req_ready === 1'b1) model_req(wen, addr, wdata, strb);
  endtask

  task automatic drain();
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    #1;
  endtask

  task automatic reset_and_wait(input logic hold, output int waited);
    @(negedge clk);
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0;
    @(negedge clk);
    i_rst = 1'b0; i_req_valid = hold;
    model_clear();
    waited = 0;
    while (o_req_ready !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (hold && o_req_ready === 1'b1) model_req(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_rsp_valid, o_rsp_wr, o_rsp_err, o_req_ready, o_init_done} !== 5'b0 ||
        o_rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b wr=%b err=%b rdy=%b done=%b rdata=%h want all 0",
               o_rsp_valid, o_rsp_wr, o_rsp_err, o_req_ready, o_init_done, o_rsp_rdata);
    end
  endtask

  task automatic test_init();
    int   waited;
    rsp_t o, e;
    reset_and_wait(1'b1, waited);
    checks++;
    if (waited != int'(DEPTH)) begin
      errors++;
      $display("FAIL init_len got %0d cycles want %0d", waited, DEPTH);
    end
    checks++;
    if (o_init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done got %b want 1", o_init_done);
    end
    drain();
    checks++;
    if (obs.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL init_rsp_count got %0d want 1", obs.size());
    end else begin
      o = obs.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.wr !== 1'b0 || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL init_read got rdata=%h err=%b wr=%b cyc=%0d want 0/0/0 cyc=%0d",
                 o.rdata, o.err, o.wr, o.cyc, e.cyc);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_write_read();
    rsp_t o, e;
    cycle_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    cycle_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drain();
    checks++;
    if (obs.size() != 2) begin
      errors++;
      $display("FAIL wr_rd_count got %0d want 2", obs.size());
    end else begin
      o = obs[0]; e = exp_q[0];
      checks++;
      if (o.wr !== 1'b1 || o.rdata !== 32'h0 || o.err !== 1'b0 || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL wr_rsp got wr=%b rdata=%h err=%b cyc=%0d want 1/0/0 cyc=%0d",
                 o.wr, o.rdata, o.err, o.cyc, e.cyc);
      end
      o = obs[1];
      checks++;
      if (o.wr !== 1'b0 || o.rdata !== 32'hDEADBEEF || o.cyc != obs[0].cyc + 1) begin
        errors++;
        $display("FAIL rd_rsp got wr=%b rdata=%h cyc=%0d want 0/deadbeef cyc=%0d",
                 o.wr, o.rdata, o.cyc, obs[0].cyc + 1);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_errors();
    rsp_t o, e;
    cycle_req(1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
    cycle_req(1'b1, 1'b1, 32'h2000, 32'h1, 4'hF);
    cycle_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    drain();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL err_count got %0d want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.wr !== e.wr || o.err !== e.err || o.rdata !== e.rdata || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL err_rsp got wr=%b err=%b rdata=%h cyc=%0d want wr=%b err=%b rdata=%h cyc=%0d",
                 o.wr, o.err, o.rdata, o.cyc, e.wr, e.err, e.rdata, e.cyc);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_streaming();
    rsp_t o;
    int   first;
    for (int i = 0; i < 16; i++) cycle_req(1'b1, 1'b1, 32'(i * 4), 32'(i), 4'hF);
    drain();
    obs.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) cycle_req(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
    drain();
    checks++;
    if (obs.size() != 16) begin
      errors++;
      $display("FAIL stream_count got %0d want 16", obs.size());
    end else begin
      first = obs[0].cyc;
      for (int i = 0; i < 16; i++) begin
        o = obs[i];
        checks++;
        if (o.rdata !== 32'(i) || o.err !== 1'b0 || o.cyc != first + i) begin
          errors++;
          $display("FAIL stream_rsp%0d got rdata=%h err=%b cyc=%0d want rdata=%h cyc=%0d",
                   i, o.rdata, o.err, o.cyc, 32'(i), first + i);
        end
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_wstrb();
    logic [31:0] want;
`ifdef DMEM_WSTRB_EN
    want = 32'hFF00FF00;
`else
    want = 32'h00000000;
`endif
    cycle_req(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    cycle_req(1'b1, 1'b1, 32'h8, 32'h00000000, 4'b0101);
    cycle_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    drain();
    checks++;
    if (obs.size() != 3) begin
      errors++;
      $display("FAIL wstrb_count got %0d want 3", obs.size());
    end else begin
      checks++;
      if (obs[2].rdata !== want) begin
        errors++;
        $display("FAIL wstrb_read got %h want %h", obs[2].rdata, want);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    rsp_t        o, e;
    logic [31:0] addr;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        1:       addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
        2:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 31) * 4);
      endcase
      cycle_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr, $urandom,
                4'($urandom_range(0, 15)));
    end
    drain();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size());
    end
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.wr !== e.wr || o.err !== e.err || o.rdata !== e.rdata || o.cyc != e.cyc) begin
        errors++;
        $display("FAIL rand_rsp got wr=%b err=%b rdata=%h cyc=%0d want wr=%b err=%b rdata=%h cyc=%0d",
                 o.wr, o.err, o.rdata, o.cyc, e.wr, e.err, e.rdata, e.cyc);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    int waited;
    cycle_req(1'b1, 1'b1, 32'h4, 32'h55, 4'hF);
    drain();
    obs.delete(); exp_q.delete();
    cycle_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    reset_and_wait(1'b0, waited);
    checks++;
    if (obs.size() != 0 || waited != int'(DEPTH)) begin
      errors++;
      $display("FAIL midflight_drop got %0d rsps, init %0d cycles want 0 rsps, %0d cycles",
               obs.size(), waited, DEPTH);
    end
    obs.delete();
    cycle_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    drain();
    checks++;
    if (obs.size() != 1) begin
      errors++;
      $display("FAIL midflight_count got %0d want 1", obs.size());
    end else begin
      checks++;
      if (obs[0].rdata !== 32'h0 || obs[0].err !== 1'b0 || obs[0].cyc != exp_q[0].cyc) begin
        errors++;
        $display("FAIL midflight_read got rdata=%h err=%b cyc=%0d want 0/0 cyc=%0d",
                 obs[0].rdata, obs[0].err, obs[0].cyc, exp_q[0].cyc);
      end
    end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_idle_zero();
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_rdata got %0d nonzero idle cycles want 0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_errors();
    test_streaming();
    test_wstrb();
    test_random();
    test_reset_midflight();
    test_idle_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
